gpio_uart: RTL
==============

# gpio_uart

Wishbone-attached UART that drives one GPIO pad and samples another through their 3-pin core interfaces. It sits directly upstream of two `gpio_wb` instances:
- `tx_gpio_*` feeds the TX pad's `cpu_gpio_out/oeb/ieb`.
- `rx_gpio_in` consumes the RX pad's `cpu_gpio_in`.

This lets firmware run a serial console on any pad pair. The CPU can still reclaim either pad through the `gpio_wb` override bits.

## Interface
- `BASE_ADR`, `32'h2100_0100`: block base; decode is `wb_adr_i[31:8] == BASE_ADR[31:8]`.
- `DIV_DEFAULT`, `16'd867`: reset value of DIV.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wb_adr_i`  in  32  address.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects; a write happens only when bit 0 is set.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_ack_o`  out  1  registered acknowledge.
- `wb_dat_o`  out  32  registered read data.
- `tx_gpio_out`  out  1  serial TX line.
- `tx_gpio_oeb`  out  1  TX drive enable, active-low.
- `tx_gpio_ieb`  out  1  TX pad input enable, active-low; tied 1.
- `rx_gpio_in`  in  1  asynchronous serial RX line.
- `rx_gpio_oeb`  out  1  RX pad drive enable; tied 1.
- `rx_gpio_ieb`  out  1  RX pad input enable; equals `~CTRL.rx_en`.
- `irq`  out  1  interrupt; present only with `GPIO_UART_IRQ_EN`.

## Operation
- Register map (offset = `wb_adr_i[7:0]`):
  - `0x00` DATA: write loads the TX byte `[7:0]`; read returns the RX byte `[7:0]` and clears `rx_valid`.
  - `0x04` CTRL: `[0]` tx_en, `[1]` rx_en, `[2]` irq_en.
  - `0x08` DIV `[15:0]`: bit period = DIV+1 clocks; values below 3 are treated as 3.
  - `0x0C` STATUS: `[0]` tx_busy, `[1]` rx_valid, `[2]` overrun, `[3]` frame_err. Bits 2 and 3 are sticky and write-1-to-clear.
  - Unmapped in-range offsets read 0 and ignore writes.
- Frame format: 8N1, LSB first; idle line is high.
- TX state machine IDLE→START→DATA(8)→STOP→IDLE:
  - A DATA write while IDLE and tx_en=1 starts a frame.
  - A DATA write while busy or with tx_en=0 is dropped silently.
  - `tx_gpio_oeb = ~tx_en`.
- RX state machine IDLE→START→DATA→STOP:
  - `rx_gpio_in` passes through a 2-flop synchronizer before any use.
  - A falling edge while IDLE and rx_en=1 enters START.
  - The line is re-sampled at (DIV+1)/2 clocks. If high, the edge is a glitch and RX returns to IDLE.
  - Data bits are sampled every DIV+1 clocks after that.
  - Stop bit sampled 0: frame_err is set and the byte is discarded.
  - Stop bit good while rx_valid=0: the byte is loaded and rx_valid is set.
  - Stop bit good while rx_valid=1: overrun is set and the old byte is kept.
- A DATA read on the same cycle as a new byte arriving: the read returns the old byte, then the new byte is loaded and rx_valid stays 1. No overrun is flagged.
- Clearing tx_en or rx_en mid-frame aborts that direction immediately:
  - TX line returns high; RX returns to IDLE.
  - STATUS is otherwise unchanged.

## Timing
- Ack: `wb_ack_o` asserts one cycle after `stb & cyc & ~ack` for an in-range address and lasts one cycle. Out-of-range accesses are never acked.
- TX latency: `tx_gpio_out` falls on the same edge that raises `wb_ack_o` for the accepted DATA write.
- TX frame: lasts exactly 10·(DIV+1) clocks. tx_busy is 1 from the ack edge through the last stop-bit clock.
- RX latency: rx_valid rises 2 (synchronizer) + (DIV+1)/2 + 9·(DIV+1) clocks after the falling start edge at the pin.
- Reset values:
  - `wb_ack_o=0`, `wb_dat_o=0`.
  - `tx_gpio_out=1`, `tx_gpio_oeb=1`, `tx_gpio_ieb=1`, `rx_gpio_oeb=1`, `rx_gpio_ieb=1`, `irq=0`.
  - CTRL=0, DIV=DIV_DEFAULT, STATUS=0, both state machines in IDLE.
- Reset asserted mid-frame: takes effect at the next edge; the TX line is high on the following cycle.

## Configuration
- `GPIO_UART_IRQ_EN` defined:
  - `irq` port exists.
  - `irq = irq_en & (rx_valid | overrun | frame_err)`, registered.
- `GPIO_UART_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL[2] reads 0 and ignores writes.

## Structure
- Package `gpio_uart_pkg`: register offsets, STATUS bit indices, TX/RX state enums, `DIV_MIN=3`.
- One sub-module, `gpio_uart_rx`: synchronizer, RX state machine and sample counter.
- The top level holds the Wishbone decode, registers and TX state machine.

## Test plan
- DIV=3, CTRL=1, write DATA=0xA5 → `tx_gpio_out` sequence, each value held 4 clocks: 0,1,0,1,0,0,1,0,1,1. tx_busy clears after 40 clocks.
- DIV=3, CTRL=2, drive frame 0x3C on `rx_gpio_in` → rx_valid=1. DATA read returns 0x3C; a following STATUS read shows rx_valid=0.
- Drive two frames 0x11 then 0x22 with no read → overrun=1 and DATA=0x11. Writing STATUS=0x4 clears overrun.
- Drive a frame with stop bit 0 → frame_err=1, rx_valid=0. A 1-clock low glitch on an idle line → no state change.
- Write DATA during busy TX → ignored and frame unchanged. Assert `wb_rst_i` mid-frame → `tx_gpio_out=1` and STATUS=0 next cycle.
- With `GPIO_UART_IRQ_EN`, CTRL=6, receive 0x55 → `irq=1`. Reading DATA deasserts `irq` on the next cycle.

Source files
------------

// File: rtl/gpio_uart_pkg.sv
// gpio_uart_pkg: shared register offsets, STATUS bit positions, TX/RX state
// encodings and the divisor clamp used by gpio_uart and gpio_uart_rx.
package gpio_uart_pkg;

    localparam logic [7:0] OFS_DATA   = 8'h00;
    localparam logic [7:0] OFS_CTRL   = 8'h04;
    localparam logic [7:0] OFS_DIV    = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;

    localparam int STAT_TX_BUSY   = 0;
    localparam int STAT_RX_VALID  = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    localparam logic [15:0] DIV_MIN = 16'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Divisor actually used for bit timing: small values are clamped so the
    // half-bit sample point in the receiver is always at least one clock out.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/gpio_uart_rx.sv
// gpio_uart_rx: 2-flop synchronizer, 8N1 receive state machine and bit-period
// sample counter. Reports a one-cycle strobe when a frame completes with a
// good stop bit (o_byte_ok) or a bad one (o_frame_err); o_data holds the byte.
module gpio_uart_rx
    import gpio_uart_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_in,
    input  logic        i_rx_en,
    input  logic [15:0] i_div,
    output logic        o_byte_ok,
    output logic        o_frame_err,
    output logic [7:0]  o_data,
    output rx_state_t   o_state
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [15:0] r_cnt;
    logic [2:0]  r_bits;
    logic [7:0]  r_shift;

    logic [15:0] w_eff;
    logic [15:0] w_half_m1;
    logic        w_fall;
    logic        w_tick;

    // (eff+1)/2 - 1 written without a 17-bit intermediate
    assign w_eff     = eff_div(i_div);
    assign w_half_m1 = (w_eff >> 1) - {15'd0, ~w_eff[0]};
    assign w_fall    = r_prev & ~r_sync2;

    // Sample strobe: half a bit into START, one full bit period otherwise
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            RX_START: w_tick = (r_cnt == w_half_m1);
            RX_DATA,
            RX_STOP:  w_tick = (r_cnt == w_eff);
            default:  w_tick = 1'b0;
        endcase
    end

    // Next-state and frame-completion strobes; disabling rx_en aborts at once
    always_comb begin
        w_next      = r_state;
        o_byte_ok   = 1'b0;
        o_frame_err = 1'b0;
        if (!i_rx_en) begin
            w_next = RX_IDLE;
        end else begin
            case (r_state)
                RX_IDLE:  if (w_fall) w_next = RX_START;
                RX_START: if (w_tick) w_next = r_sync2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_tick && r_bits == 3'd7) w_next = RX_STOP;
                RX_STOP: begin
                    if (w_tick) begin
                        w_next      = RX_IDLE;
                        o_byte_ok   = r_sync2;
                        o_frame_err = ~r_sync2;
                    end
                end
                default:  w_next = RX_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= RX_IDLE;
        else       r_state <= w_next;
    end

    // Synchronizer, edge history, sample counter and LSB-first shift register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= 16'd0;
            r_bits  <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_state == RX_IDLE || w_next != r_state || w_tick) r_cnt <= 16'd0;
            else                                                   r_cnt <= r_cnt + 16'd1;
            if (r_state == RX_START) begin
                r_bits <= 3'd0;
            end else if (r_state == RX_DATA && w_tick) begin
                r_bits  <= r_bits + 3'd1;
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    assign o_data  = r_shift;
    assign o_state = r_state;

endmodule

// File: rtl/gpio_uart.sv
// gpio_uart: Wishbone-attached 8N1 UART driving a TX GPIO pad and sampling an
// RX GPIO pad through their 3-pin core interfaces. Holds the bus decode,
// CTRL/DIV/STATUS registers and the transmit state machine.
// Optional feature macro: GPIO_UART_IRQ_EN adds the registered irq output
// and the CTRL[2] irq_en bit.
//
// Handshake: an access is taken on any clock where cyc & stb & ~ack and the
// address is in this block's 256-byte window; ack is raised on the next edge
// for exactly one cycle, with read data registered alongside it.
module gpio_uart
    import gpio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h2100_0100,
    parameter logic [15:0] DIV_DEFAULT = 16'd867
)(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        tx_gpio_out,
    output logic        tx_gpio_oeb,
    output logic        tx_gpio_ieb,
    input  logic        rx_gpio_in,
    output logic        rx_gpio_oeb,
    output logic        rx_gpio_ieb
`ifdef GPIO_UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_tx_en;
    logic        r_rx_en;
    logic [15:0] r_div;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_frame_err;
    logic [7:0]  r_rx_byte;

    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bits;
    logic [7:0]  r_tx_shift;
    logic        r_tx_out;

    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic [7:0]  w_ofs;
    logic        w_data_rd;
    logic        w_stat_wr;
    logic        w_tx_start;
    logic        w_tx_tick;
    logic        w_tx_busy;
    logic [15:0] w_eff;
    logic [3:0]  w_status;
    logic        w_irq_en;
    logic        w_rx_ok;
    logic        w_rx_ferr;
    logic [7:0]  w_rx_data;
    rx_state_t   w_rx_state;
    logic        w_unused;

    assign w_ofs      = wb_adr_i[7:0];
    assign w_hit      = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign w_acc      = w_hit & ~r_ack;
    assign w_wr       = w_acc & wb_we_i & wb_sel_i[0];
    assign w_rd       = w_acc & ~wb_we_i;
    assign w_data_rd  = w_rd & (w_ofs == OFS_DATA);
    assign w_stat_wr  = w_wr & (w_ofs == OFS_STATUS);
    assign w_eff      = eff_div(r_div);
    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    assign w_tx_tick  = (r_tx_state != TX_IDLE) && (r_tx_cnt == w_eff);
    assign w_tx_start = w_wr & (w_ofs == OFS_DATA) & r_tx_en & (r_tx_state == TX_IDLE);

    assign w_status[STAT_TX_BUSY]   = w_tx_busy;
    assign w_status[STAT_RX_VALID]  = r_rx_valid;
    assign w_status[STAT_OVERRUN]   = r_overrun;
    assign w_status[STAT_FRAME_ERR] = r_frame_err;

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat_o;
    assign tx_gpio_out = r_tx_out;
    assign tx_gpio_oeb = ~r_tx_en;
    assign tx_gpio_ieb = 1'b1;
    assign rx_gpio_oeb = 1'b1;
    assign rx_gpio_ieb = ~r_rx_en;

    assign w_unused = &{1'b0, wb_dat_i[31:16], wb_sel_i[3:1], w_rx_state};

    gpio_uart_rx u_rx (
        .i_clk       (wb_clk_i),
        .i_rst       (wb_rst_i),
        .i_rx_in     (rx_gpio_in),
        .i_rx_en     (r_rx_en),
        .i_div       (r_div),
        .o_byte_ok   (w_rx_ok),
        .o_frame_err (w_rx_ferr),
        .o_data      (w_rx_data),
        .o_state     (w_rx_state)
    );

    // Single-cycle acknowledge for in-window accesses
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_ack <= 1'b0;
        else          r_ack <= w_acc;
    end

    // Registered read mux; zero outside read acks
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dat_o <= 32'd0;
        end else if (w_rd) begin
            case (w_ofs)
                OFS_DATA:   r_dat_o <= {24'd0, r_rx_byte};
                OFS_CTRL:   r_dat_o <= {29'd0, w_irq_en, r_rx_en, r_tx_en};
                OFS_DIV:    r_dat_o <= {16'd0, r_div};
                OFS_STATUS: r_dat_o <= {28'd0, w_status};
                default:    r_dat_o <= 32'd0;
            endcase
        end else begin
            r_dat_o <= 32'd0;
        end
    end

    // CTRL enables and DIV
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_en <= 1'b0;
            r_rx_en <= 1'b0;
            r_div   <= DIV_DEFAULT;
        end else if (w_wr) begin
            case (w_ofs)
                OFS_CTRL: begin
                    r_tx_en <= wb_dat_i[0];
                    r_rx_en <= wb_dat_i[1];
                end
                OFS_DIV:  r_div <= wb_dat_i[15:0];
                default:  ;
            endcase
        end
    end

    // Receive holding register and sticky flags; a DATA read coinciding with
    // a new byte returns the old byte and the new one replaces it silently
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_byte   <= 8'd0;
        end else begin
            if (w_rx_ok && (!r_rx_valid || w_data_rd)) begin
                r_rx_byte  <= w_rx_data;
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_ok && r_rx_valid && !w_data_rd) r_overrun <= 1'b1;
            else if (w_stat_wr && wb_dat_i[STAT_OVERRUN]) r_overrun <= 1'b0;
            if (w_rx_ferr) r_frame_err <= 1'b1;
            else if (w_stat_wr && wb_dat_i[STAT_FRAME_ERR]) r_frame_err <= 1'b0;
        end
    end

    // TX next-state; clearing tx_en returns to IDLE from any state
    always_comb begin
        w_tx_next = r_tx_state;
        if (!r_tx_en) begin
            w_tx_next = TX_IDLE;
        end else begin
            case (r_tx_state)
                TX_IDLE:  if (w_tx_start) w_tx_next = TX_START;
                TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
                TX_DATA:  if (w_tx_tick && r_tx_bits == 3'd7) w_tx_next = TX_STOP;
                TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
                default:  w_tx_next = TX_IDLE;
            endcase
        end
    end

    // TX state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    // TX bit counter, shifter and registered line level
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_cnt   <= 16'd0;
            r_tx_bits  <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_out   <= 1'b1;
        end else begin
            if (r_tx_state == TX_IDLE || w_tx_next != r_tx_state || w_tx_tick) r_tx_cnt <= 16'd0;
            else                                                              r_tx_cnt <= r_tx_cnt + 16'd1;
            case (w_tx_next)
                TX_START: r_tx_out <= 1'b0;
                TX_DATA:  if (r_tx_state == TX_START || w_tx_tick) r_tx_out <= r_tx_shift[0];
                default:  r_tx_out <= 1'b1;
            endcase
            if (w_tx_start) begin
                r_tx_shift <= wb_dat_i[7:0];
            end else if ((r_tx_state == TX_START || r_tx_state == TX_DATA) && w_tx_tick) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
            if (r_tx_state == TX_START)                  r_tx_bits <= 3'd0;
            else if (r_tx_state == TX_DATA && w_tx_tick) r_tx_bits <= r_tx_bits + 3'd1;
        end
    end

`ifdef GPIO_UART_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // irq_en bit and registered interrupt level
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && w_ofs == OFS_CTRL) r_irq_en <= wb_dat_i[2];
            r_irq <= r_irq_en & (r_rx_valid | r_overrun | r_frame_err);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

endmodule
